// File: rtl/cpu_ctrl_pkg.sv
// Shared state encoding for the CPU run/pause/step/breakpoint controller.
// The localparams give the raw codes; the enum is what the FSM actually carries.
package cpu_ctrl_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] RUN   = 2'b00;
    localparam logic [STATE_W-1:0] PAUSE = 2'b01;
    localparam logic [STATE_W-1:0] ADV   = 2'b10;
    localparam logic [STATE_W-1:0] HALT  = 2'b11;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN   = RUN,
        ST_PAUSE = PAUSE,
        ST_ADV   = ADV,
        ST_HALT  = HALT
    } run_state_e;

endpackage

// File: rtl/go_debounce.sv
// Conditions the raw go push button: 2-flop synchronizer, debounce counter
// and a registered one-cycle pulse on each accepted 0->1 change of the level.
module go_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic go,
    output logic go_pulse
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic          pulse_q;
    logic          pulse_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Debounce next state: any sample equal to the stable level restarts the count.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        pulse_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == LAST_CNT) begin
                cnt_d    = '0;
                stable_d = ~stable_q;
                pulse_d  = ~stable_q;
            end else begin
                cnt_d    = cnt_q + CW'(1);
                stable_d = stable_q;
                pulse_d  = 1'b0;
            end
        end else begin
            cnt_d    = '0;
            stable_d = stable_q;
            pulse_d  = 1'b0;
        end
    end

    // Synchronizer, debounce and pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= go;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
        end
    end

    assign go_pulse = pulse_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/pause/step/breakpoint controller for the single-cycle MIPS CPU: gates PC
// advance and commits, and keeps saturating retire/jump/branch statistics.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int DB_CYCLES = 500000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic               step_mode,
    input  logic               syscall,
    input  logic               show,
    input  logic               bp_en,
    input  logic [9:0]         bp_addr,
    input  logic [9:0]         pc_addr,
    input  logic               jmp,
    input  logic               branch,
    output logic               pc_enable,
    output logic [STATE_W-1:0] state,
    output logic               halted,
    output logic [CNT_W-1:0]   instr_cnt,
    output logic [CNT_W-1:0]   jmp_cnt,
    output logic [CNT_W-1:0]   branch_cnt
);

    run_state_e       state_q;
    run_state_e       state_d;
    logic             halted_q;
    logic             go_pulse_s;
    logic             exit_s;
    logic             stop_s;
    logic             pc_en_s;
    logic [CNT_W-1:0] instr_q;
    logic [CNT_W-1:0] jmp_q;
    logic [CNT_W-1:0] branch_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + CNT_W'(1);
        end else begin
            return v;
        end
    endfunction

    go_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_go_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go),
        .go_pulse (go_pulse_s)
    );

    assign exit_s = syscall & ~show;
    assign stop_s = syscall | (bp_en & (pc_addr == bp_addr));

    // Commit strobe and next state; ADV retires the stopping instruction without re-trapping it.
    always_comb begin
        pc_en_s = 1'b0;
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (exit_s) begin
                    state_d = ST_HALT;
                end else if (stop_s) begin
                    state_d = ST_PAUSE;
                end else begin
                    pc_en_s = 1'b1;
                    state_d = step_mode ? ST_PAUSE : ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (go_pulse_s) begin
                    state_d = ST_ADV;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_ADV: begin
                if (exit_s) begin
                    state_d = ST_HALT;
                end else begin
                    pc_en_s = 1'b1;
                    state_d = step_mode ? ST_PAUSE : ST_RUN;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State, halted flag and statistics counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
            instr_q  <= '0;
            jmp_q    <= '0;
            branch_q <= '0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == ST_HALT);
            instr_q  <= sat_inc(instr_q, pc_en_s);
            jmp_q    <= sat_inc(jmp_q, pc_en_s & jmp);
            branch_q <= sat_inc(branch_q, pc_en_s & branch);
        end
    end

    assign pc_enable  = pc_en_s;
    assign state      = state_q;
    assign halted     = halted_q;
    assign instr_cnt  = instr_q;
    assign jmp_cnt    = jmp_q;
    assign branch_cnt = branch_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl with DB_CYCLES=4 and CNT_W=4: a vector
// table through a scoreboard queue, then a hand-written held-button sequence.
module tb_cpu_run_ctrl;

    localparam int DB = 4;
    localparam int CW = 4;
    localparam logic [1:0] S_RUN   = 2'b00;
    localparam logic [1:0] S_PAUSE = 2'b01;
    localparam logic [1:0] S_ADV   = 2'b10;
    localparam logic [1:0] S_HALT  = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          go = 1'b0;
    logic          step_mode = 1'b0;
    logic          syscall = 1'b0;
    logic          show = 1'b0;
    logic          bp_en = 1'b0;
    logic [9:0]    bp_addr = 10'd0;
    logic [9:0]    pc_addr = 10'd0;
    logic          jmp = 1'b0;
    logic          branch = 1'b0;
    logic          pc_enable;
    logic [1:0]    state;
    logic          halted;
    logic [CW-1:0] instr_cnt;
    logic [CW-1:0] jmp_cnt;
    logic [CW-1:0] branch_cnt;

    typedef struct {
        logic       rst_n;
        logic       step;
        logic       sc;
        logic       show;
        logic       bp_en;
        logic [9:0] bp_addr;
        logic [9:0] pc;
        logic       jmp;
        logic       br;
        logic       go;
        logic       chk_pc;
        logic       e_pc;
        logic [1:0] e_st;
        logic [3:0] e_i;
        logic [3:0] e_j;
        logic [3:0] e_b;
    } vec_t;

    vec_t tbl[$];
    vec_t sb_q[$];
    vec_t cur;
    int   checks = 0;
    int   failures = 0;
    int   vi = 0;

    cpu_run_ctrl #(
        .CNT_W     (CW),
        .DB_CYCLES (DB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .go         (go),
        .step_mode  (step_mode),
        .syscall    (syscall),
        .show       (show),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc_addr    (pc_addr),
        .jmp        (jmp),
        .branch     (branch),
        .pc_enable  (pc_enable),
        .state      (state),
        .halted     (halted),
        .instr_cnt  (instr_cnt),
        .jmp_cnt    (jmp_cnt),
        .branch_cnt (branch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%0h expected=%0h", nm, vi, act, exp);
        end
    endtask

    task automatic add(input logic e_pc, input logic [1:0] e_st, input int e_i, input int e_j, input int e_b);
        vec_t v;
        v        = cur;
        v.chk_pc = 1'b1;
        v.e_pc   = e_pc;
        v.e_st   = e_st;
        v.e_i    = 4'(e_i);
        v.e_j    = 4'(e_j);
        v.e_b    = 4'(e_b);
        tbl.push_back(v);
    endtask

    task automatic add_rst();
        vec_t v;
        v        = cur;
        v.rst_n  = 1'b0;
        v.chk_pc = 1'b0;
        v.e_pc   = 1'b0;
        v.e_st   = S_RUN;
        v.e_i    = 4'd0;
        v.e_j    = 4'd0;
        v.e_b    = 4'd0;
        tbl.push_back(v);
    endtask

    // Clean press while paused: DB+2 edges to the pulse, one more edge into ADV.
    task automatic add_press(input int e_i, input int e_j, input int e_b);
        cur.go = 1'b1;
        for (int i = 0; i < DB + 2; i++) add(1'b0, S_PAUSE, e_i, e_j, e_b);
        add(1'b0, S_ADV, e_i, e_j, e_b);
    endtask

    task automatic build_table();
        cur = '{default: '0};
        cur.rst_n = 1'b1;
        add_rst();
        // free run
        for (int k = 1; k <= 10; k++) add(1'b1, S_RUN, k, 0, 0);
        add_rst();
        // breakpoint at word 5, then one go retires it
        cur.bp_en   = 1'b1;
        cur.bp_addr = 10'd5;
        for (int a = 0; a < 5; a++) begin
            cur.pc = 10'(a);
            add(1'b1, S_RUN, a + 1, 0, 0);
        end
        cur.pc = 10'd5;
        add(1'b0, S_PAUSE, 5, 0, 0);
        add(1'b0, S_PAUSE, 5, 0, 0);
        add_press(5, 0, 0);
        add(1'b1, S_RUN, 6, 0, 0);
        cur.go = 1'b0;
        cur.pc = 10'd6;
        add(1'b1, S_RUN, 7, 0, 0);
        cur.bp_en = 1'b0;
        for (int i = 0; i < DB + 2; i++) begin
            cur.pc = 10'(7 + i);
            add(1'b1, S_RUN, 8 + i, 0, 0);
        end
        add_rst();
        // display syscall pauses, exit syscall halts, HALT ignores go
        cur.sc   = 1'b1;
        cur.show = 1'b1;
        add(1'b0, S_PAUSE, 0, 0, 0);
        add_press(0, 0, 0);
        add(1'b1, S_RUN, 1, 0, 0);
        cur.go   = 1'b0;
        cur.sc   = 1'b0;
        cur.show = 1'b0;
        add(1'b1, S_RUN, 2, 0, 0);
        cur.sc = 1'b1;
        add(1'b0, S_HALT, 2, 0, 0);
        for (int i = 0; i < DB + 2; i++) add(1'b0, S_HALT, 2, 0, 0);
        cur.go = 1'b1;
        for (int i = 0; i < DB + 4; i++) add(1'b0, S_HALT, 2, 0, 0);
        cur.go = 1'b0;
        for (int i = 0; i < DB + 2; i++) add(1'b0, S_HALT, 2, 0, 0);
        cur.sc = 1'b0;
        add_rst();
        // step mode: one retire per accepted press, short bounce ignored
        cur.step = 1'b1;
        add(1'b1, S_PAUSE, 1, 0, 0);
        add_press(1, 0, 0);
        add(1'b1, S_PAUSE, 2, 0, 0);
        cur.go = 1'b0;
        for (int i = 0; i < DB + 2; i++) add(1'b0, S_PAUSE, 2, 0, 0);
        add_press(2, 0, 0);
        add(1'b1, S_PAUSE, 3, 0, 0);
        cur.go = 1'b0;
        for (int i = 0; i < DB + 2; i++) add(1'b0, S_PAUSE, 3, 0, 0);
        cur.go = 1'b1;
        for (int i = 0; i < 3; i++) add(1'b0, S_PAUSE, 3, 0, 0);
        cur.go = 1'b0;
        for (int i = 0; i < DB + 4; i++) add(1'b0, S_PAUSE, 3, 0, 0);
        cur.step = 1'b0;
        add_rst();
        // saturation with jumps, then taken branches
        cur.jmp = 1'b1;
        for (int k = 1; k <= 20; k++) add(1'b1, S_RUN, (k > 15) ? 15 : k, (k > 15) ? 15 : k, 0);
        cur.jmp = 1'b0;
        cur.br  = 1'b1;
        for (int k = 1; k <= 3; k++) add(1'b1, S_RUN, 15, 15, k);
        cur.br = 1'b0;
        // exit wins over a simultaneous breakpoint hit
        cur.sc      = 1'b1;
        cur.bp_en   = 1'b1;
        cur.bp_addr = cur.pc;
        add(1'b0, S_HALT, 15, 15, 3);
        cur.sc    = 1'b0;
        cur.bp_en = 1'b0;
        add_rst();
        add(1'b1, S_RUN, 1, 0, 0);
    endtask

    task automatic drive(input vec_t v);
        rst_n     = v.rst_n;
        step_mode = v.step;
        syscall   = v.sc;
        show      = v.show;
        bp_en     = v.bp_en;
        bp_addr   = v.bp_addr;
        pc_addr   = v.pc;
        jmp       = v.jmp;
        branch    = v.br;
        go        = v.go;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        int   n_pc;
        int   first_idx;

        build_table();
        @(negedge clk);
        foreach (tbl[i]) begin
            vi = i;
            drive(tbl[i]);
            sb_q.push_back(tbl[i]);
            #1;
            if (tbl[i].chk_pc) chk("pc_enable", 32'(pc_enable), 32'(tbl[i].e_pc));
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            chk("state", 32'(state), 32'(e.e_st));
            chk("halted", 32'(halted), 32'(e.e_st == S_HALT));
            chk("instr_cnt", 32'(instr_cnt), 32'(e.e_i));
            chk("jmp_cnt", 32'(jmp_cnt), 32'(e.e_j));
            chk("branch_cnt", 32'(branch_cnt), 32'(e.e_b));
            @(negedge clk);
        end

        // Held go in step mode: exactly one retire, DB+3 cycles after the rise.
        vi = -1;
        cur = '{default: '0};
        drive(cur);
        @(negedge clk);
        rst_n     = 1'b1;
        step_mode = 1'b1;
        @(negedge clk);
        chk("held_setup_state", 32'(state), 32'(S_PAUSE));
        go        = 1'b1;
        n_pc      = 0;
        first_idx = -1;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (pc_enable) begin
                n_pc++;
                if (first_idx < 0) first_idx = c;
            end
            @(negedge clk);
        end
        if (first_idx < 0) begin
            checks++;
            failures++;
            $display("FAIL held_go_wait actual=no_pc_enable expected=pc_enable within 30 cycles");
        end else begin
            chk("held_go_latency", 32'(first_idx), 32'(DB + 3));
        end
        chk("held_go_retires", 32'(n_pc), 32'd1);
        chk("held_go_instr", 32'(instr_cnt), 32'd2);
        chk("held_go_state", 32'(state), 32'(S_PAUSE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
